// File: rtl/frame_buffer_reader.sv
// rtl/frame_buffer_reader.sv - Avalon-MM frame buffer scan-out reader feeding the LCD pixel stream
module frame_buffer_reader #(
    parameter logic [31:0] FB_ADDRESS = 32'h0000_0000,
    parameter int          FB_WIDTH   = 800,
    parameter int          FB_HEIGHT  = 480,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frame_start,
    output logic [28:0] address,
    output logic [7:0]  burstcount,
    output logic        read,
    input  logic        waitrequest,
    input  logic [63:0] readdata,
    input  logic        readdatavalid,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic [23:0] pixel_data,
    output logic        pixel_first,
    output logic        pixel_last,
    output logic        underflow
);
    localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW        = AW + 1;
    localparam logic [19:0] W_WORDS   = 20'(FB_WIDTH * FB_HEIGHT / 2);
    localparam logic [19:0] PIX_TOTAL = 20'(FB_WIDTH * FB_HEIGHT);
    localparam logic [19:0] PIX_LAST  = PIX_TOTAL - 20'd1;
    localparam logic [20:0] DEPTH_W   = 21'(FIFO_DEPTH);
    localparam logic [28:0] BASE_WORD = FB_ADDRESS[31:3];

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic          read_q, read_d;
    logic [28:0]   address_q, address_d;
    logic [19:0]   requested_q, requested_d;
    logic [19:0]   outstanding_q, outstanding_d;
    logic          restart_pending_q, restart_pending_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fifo_count_q, fifo_count_d;
    logic          half_q, half_d;
    logic [19:0]   pix_cnt_q, pix_cnt_d;
    logic          underflow_q, underflow_d;
    logic [47:0]   fifo_mem_q [FIFO_DEPTH];

    logic          accept, hold, active, rdv_dec, push, pop, pix_avail, pix_fire;
    logic [47:0]   head;
    logic [23:0]   half_sel;
    logic [20:0]   reserved;
    logic          unused_readdata;

    // FIFO keeps only the 24 colour bits of each half-word
    assign unused_readdata = &{1'b0, readdata[63:56], readdata[31:24]};

    always_comb begin
        accept    = read_q && !waitrequest;
        hold      = read_q && waitrequest;
        active    = (state_q == S_FETCH) || (state_q == S_DONE);
        rdv_dec   = readdatavalid && (state_q != S_IDLE) && (outstanding_q != 20'd0);
        push      = rdv_dec && active && !frame_start;
        head      = fifo_mem_q[rd_ptr_q];
        pix_avail = (fifo_count_q != '0) && active && (pix_cnt_q < PIX_TOTAL);
        pix_fire  = pix_avail && pixel_ready && !frame_start;
        pop       = pix_fire && half_q;

        outstanding_d     = outstanding_q + 20'(accept) - 20'(rdv_dec);
        restart_pending_d = restart_pending_q && !accept;

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        half_d       = half_q;
        pix_cnt_d    = pix_cnt_q;
        underflow_d  = underflow_q;
        if (frame_start && state_q != S_DRAIN) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fifo_count_d = '0;
            half_d       = 1'b0;
            pix_cnt_d    = '0;
            underflow_d  = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
            if (pix_fire) begin
                half_d    = !half_q;
                pix_cnt_d = pix_cnt_q + 20'd1;
            end
            if (pixel_ready && !pix_avail && active && (pix_cnt_q < PIX_TOTAL)) underflow_d = 1'b1;
        end

        state_d     = state_q;
        address_d   = address_q + 29'(accept);
        requested_d = requested_q + 20'(accept);
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d     = S_FETCH;
                    address_d   = BASE_WORD;
                    requested_d = '0;
                end
            end
            S_FETCH, S_DONE: begin
                if (frame_start) begin
                    // a stalled read cannot be withdrawn; its data is dropped in DRAIN
                    if (hold) restart_pending_d = 1'b1;
                    if (outstanding_d != '0 || hold) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d     = S_FETCH;
                        address_d   = BASE_WORD;
                        requested_d = '0;
                    end
                end else if (state_q == S_FETCH && requested_d == W_WORDS) begin
                    state_d = S_DONE;
                end
            end
            S_DRAIN: begin
                if (outstanding_d == '0 && !restart_pending_d && !hold) begin
                    state_d     = S_FETCH;
                    address_d   = BASE_WORD;
                    requested_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // every issued read owns a FIFO slot, so returning data can never overflow it
        reserved = 21'(fifo_count_d) + {1'b0, outstanding_d};
        if (hold)                    read_d = 1'b1;
        else if (state_d == S_FETCH) read_d = (reserved < DEPTH_W) && (requested_d < W_WORDS);
        else                         read_d = 1'b0;

        half_sel = half_q ? head[47:24] : head[23:0];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q           <= S_IDLE;
            read_q            <= 1'b0;
            address_q         <= BASE_WORD;
            requested_q       <= '0;
            outstanding_q     <= '0;
            restart_pending_q <= 1'b0;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            fifo_count_q      <= '0;
            half_q            <= 1'b0;
            pix_cnt_q         <= '0;
            underflow_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            read_q            <= read_d;
            address_q         <= address_d;
            requested_q       <= requested_d;
            outstanding_q     <= outstanding_d;
            restart_pending_q <= restart_pending_d;
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            fifo_count_q      <= fifo_count_d;
            half_q            <= half_d;
            pix_cnt_q         <= pix_cnt_d;
            underflow_q       <= underflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {readdata[55:32], readdata[23:0]};
    end

    assign address     = address_q;
    assign burstcount  = 8'h01;
    assign read        = read_q;
    assign pixel_valid = pix_avail;
    assign pixel_data  = {half_sel[7:0], half_sel[15:8], half_sel[23:16]};
    assign pixel_first = pix_avail && (pix_cnt_q == 20'd0);
    assign pixel_last  = pix_avail && (pix_cnt_q == PIX_LAST);
    assign underflow   = underflow_q;
endmodule

// File: tb/tb_frame_buffer_reader.sv
// tb/tb_frame_buffer_reader.sv - directed self-checking bench for frame_buffer_reader
module tb_frame_buffer_reader;
    localparam logic [28:0] BASE_W = 29'h20;
    localparam int          NPIX   = 16;
    localparam int          NWORD  = 8;

    typedef struct packed {
        logic [23:0] data;
        logic        first;
        logic        last;
    } pix_t;

    typedef struct packed {
        logic [28:0] addr;
        logic [31:0] due;
    } req_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        frame_start;
    logic [28:0] address;
    logic [7:0]  burstcount;
    logic        read;
    logic        waitrequest = 1'b0;
    logic [63:0] readdata = 64'h0;
    logic        readdatavalid = 1'b0;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [23:0] pixel_data;
    logic        pixel_first;
    logic        pixel_last;
    logic        underflow;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   mem_lat;
    int   stall_total;
    int   stall_done = 0;
    req_t pend[$];
    logic [28:0] acc_q[$];
    pix_t pix_q[$];

    frame_buffer_reader #(
        .FB_ADDRESS(32'h0000_0100),
        .FB_WIDTH  (4),
        .FB_HEIGHT (4),
        .FIFO_DEPTH(4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .frame_start  (frame_start),
        .address      (address),
        .burstcount   (burstcount),
        .read         (read),
        .waitrequest  (waitrequest),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .pixel_data   (pixel_data),
        .pixel_first  (pixel_first),
        .pixel_last   (pixel_last),
        .underflow    (underflow)
    );

    always #5 clock = ~clock;

    function automatic logic [23:0] mem_half(int p);
        return {8'h80 + p[7:0], 8'h40 + p[7:0], 8'h10 + p[7:0]};
    endfunction

    function automatic logic [23:0] exp_pix(int p);
        return {8'h10 + p[7:0], 8'h40 + p[7:0], 8'h80 + p[7:0]};
    endfunction

    function automatic logic [63:0] mem_word(logic [28:0] a);
        int n;
        n = int'(a - BASE_W);
        return {8'hEE, mem_half(2 * n + 1), 8'hDD, mem_half(2 * n)};
    endfunction

    // memory slave: decides waitrequest/readdata on the falling edge for the next rising edge
    always @(negedge clock) begin
        cyc = cyc + 1;
        readdatavalid = 1'b0;
        if (pend.size() != 0 && pend[0].due <= 32'(cyc)) begin
            readdata = mem_word(pend[0].addr);
            readdatavalid = 1'b1;
            void'(pend.pop_front());
        end
        waitrequest = 1'b0;
        if (read && stall_done < stall_total) begin
            waitrequest = 1'b1;
            stall_done++;
        end
        if (read && !waitrequest) begin
            pend.push_back({address, 32'(cyc + mem_lat)});
            acc_q.push_back(address);
        end
    end

    always @(negedge clock) begin
        if (reset_n && pixel_valid && pixel_ready)
            pix_q.push_back({pixel_data, pixel_first, pixel_last});
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_valid(output bit to);
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (pixel_valid) begin
                to = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_done(input int target, output bit to);
        to = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (pix_q.size() >= target && pend.size() == 0) begin
                to = 1'b0;
                break;
            end
            tick();
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        total++; if (read !== 1'b0) begin bad++; $display("FAIL reset_read got=%b exp=0", read); end
        total++; if (address !== BASE_W) begin bad++; $display("FAIL reset_address got=%h exp=%h", address, BASE_W); end
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", pixel_valid); end
        total++; if (pixel_first !== 1'b0 || pixel_last !== 1'b0) begin bad++; $display("FAIL reset_first_last got=%b%b exp=00", pixel_first, pixel_last); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
        total++; if (burstcount !== 8'h01) begin bad++; $display("FAIL burstcount got=%h exp=01", burstcount); end
        reset_n = 1'b1;
        repeat (3) tick();
        total++; if (read !== 1'b0) begin bad++; $display("FAIL idle_no_read got=%b exp=0", read); end
    endtask

    task automatic test_frame();
        int ab, pb;
        bit to;
        pixel_ready = 1'b0;
        mem_lat = 1;
        ab = acc_q.size();
        pb = pix_q.size();
        pulse_frame();
        total++; if (read !== 1'b1 || address !== BASE_W) begin bad++; $display("FAIL frame_first_read got=%b/%h exp=1/%h", read, address, BASE_W); end
        wait_valid(to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL frame_wait_valid got=timeout exp=valid"); end
        pixel_ready = 1'b1;
        wait_done(pb + NPIX, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL frame_done got=%0d pixels exp=%0d", pix_q.size() - pb, NPIX); end
        total++; if (acc_q.size() - ab !== NWORD) begin bad++; $display("FAIL frame_read_count got=%0d exp=%0d", acc_q.size() - ab, NWORD); end
        for (int i = 0; i < NWORD; i++) begin
            total++;
            if (acc_q[ab + i] !== BASE_W + 29'(i)) begin bad++; $display("FAIL frame_addr[%0d] got=%h exp=%h", i, acc_q[ab + i], BASE_W + 29'(i)); end
        end
        for (int i = 0; i < NPIX; i++) begin
            total++;
            if (pix_q[pb + i].data !== exp_pix(i) || pix_q[pb + i].first !== (i == 0) || pix_q[pb + i].last !== (i == NPIX - 1)) begin
                bad++;
                $display("FAIL frame_pix[%0d] got=%h f%b l%b exp=%h f%b l%b", i, pix_q[pb + i].data, pix_q[pb + i].first, pix_q[pb + i].last, exp_pix(i), i == 0, i == NPIX - 1);
            end
        end
        total++; if (pixel_valid !== 1'b0 || read !== 1'b0) begin bad++; $display("FAIL frame_end_idle got=valid%b read%b exp=0/0", pixel_valid, read); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL frame_underflow got=%b exp=0", underflow); end
    endtask

    task automatic test_backpressure();
        int ab, pb;
        bit to;
        pixel_ready = 1'b0;
        mem_lat = 3;
        ab = acc_q.size();
        pb = pix_q.size();
        pulse_frame();
        repeat (20) tick();
        total++; if (acc_q.size() - ab !== 4) begin bad++; $display("FAIL bp_reserved_reads got=%0d exp=4", acc_q.size() - ab); end
        total++; if (read !== 1'b0) begin bad++; $display("FAIL bp_read_stopped got=%b exp=0", read); end
        total++; if (pixel_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", pixel_valid); end
        pixel_ready = 1'b1;
        wait_done(pb + NPIX, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL bp_done got=%0d pixels exp=%0d", pix_q.size() - pb, NPIX); end
        total++; if (acc_q.size() - ab !== NWORD) begin bad++; $display("FAIL bp_read_count got=%0d exp=%0d", acc_q.size() - ab, NWORD); end
        for (int i = 0; i < NPIX; i++) begin
            total++;
            if (pix_q[pb + i].data !== exp_pix(i)) begin bad++; $display("FAIL bp_pix[%0d] got=%h exp=%h", i, pix_q[pb + i].data, exp_pix(i)); end
        end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL bp_underflow got=%b exp=0", underflow); end
    endtask

    task automatic test_waitrequest();
        int ab, pb;
        bit to;
        pixel_ready = 1'b0;
        mem_lat = 2;
        stall_total = stall_done + 5;
        ab = acc_q.size();
        pb = pix_q.size();
        pulse_frame();
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++;
            if (read !== 1'b1 || address !== BASE_W || acc_q.size() - ab !== 0) begin
                bad++;
                $display("FAIL wait_hold[%0d] got=read%b addr%h acc%0d exp=1/%h/0", i, read, address, acc_q.size() - ab, BASE_W);
            end
        end
        tick();
        total++; if (acc_q.size() - ab !== 1) begin bad++; $display("FAIL wait_one_accept got=%0d exp=1", acc_q.size() - ab); end
        total++; if (address !== BASE_W + 29'd1) begin bad++; $display("FAIL wait_next_addr got=%h exp=%h", address, BASE_W + 29'd1); end
        wait_valid(to);
        pixel_ready = 1'b1;
        wait_done(pb + NPIX, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL wait_done got=%0d pixels exp=%0d", pix_q.size() - pb, NPIX); end
    endtask

    task automatic test_restart_drain();
        int pb;
        bit to;
        pixel_ready = 1'b0;
        mem_lat = 4;
        pulse_frame();
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (pend.size() == 2 && pixel_valid) begin
                to = 1'b0;
                break;
            end
            tick();
        end
        total++; if (to !== 1'b0) begin bad++; $display("FAIL drain_setup got=timeout exp=2 outstanding"); end
        pb = pix_q.size();
        pulse_frame();
        total++; if (read !== 1'b0 || pixel_valid !== 1'b0) begin bad++; $display("FAIL drain_quiet got=read%b valid%b exp=0/0", read, pixel_valid); end
        tick();
        total++; if (pend.size() !== 0) begin bad++; $display("FAIL drain_consumed got=%0d exp=0", pend.size()); end
        total++; if (read !== 1'b1 || address !== BASE_W) begin bad++; $display("FAIL drain_refetch got=read%b addr%h exp=1/%h", read, address, BASE_W); end
        wait_valid(to);
        pixel_ready = 1'b1;
        wait_done(pb + NPIX, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL drain_done got=%0d pixels exp=%0d", pix_q.size() - pb, NPIX); end
        for (int i = 0; i < NPIX; i++) begin
            total++;
            if (pix_q[pb + i].data !== exp_pix(i) || pix_q[pb + i].first !== (i == 0)) begin
                bad++;
                $display("FAIL drain_pix[%0d] got=%h f%b exp=%h f%b", i, pix_q[pb + i].data, pix_q[pb + i].first, exp_pix(i), i == 0);
            end
        end
    endtask

    task automatic test_underflow();
        bit to;
        int pb;
        pixel_ready = 1'b0;
        mem_lat = 10;
        pb = pix_q.size();
        pulse_frame();
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL uf_start got=%b exp=0", underflow); end
        pixel_ready = 1'b1;
        tick();
        total++; if (underflow !== 1'b1 || pixel_valid !== 1'b0) begin bad++; $display("FAIL uf_set got=uf%b valid%b exp=1/0", underflow, pixel_valid); end
        wait_done(pb + NPIX, to);
        pixel_ready = 1'b0;
        tick();
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%b exp=1", underflow); end
        mem_lat = 3;
        pulse_frame();
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL uf_clear got=%b exp=0", underflow); end
    endtask

    task automatic test_reset_mid_frame();
        int ab, pb, busy;
        bit to;
        repeat (2) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        total++; if (read !== 1'b0 || pixel_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_quiet got=read%b valid%b exp=0/0", read, pixel_valid); end
        total++; if (address !== BASE_W || underflow !== 1'b0) begin bad++; $display("FAIL rst_mid_regs got=addr%h uf%b exp=%h/0", address, underflow, BASE_W); end
        ab = acc_q.size();
        busy = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (read || pixel_valid) busy++;
        end
        total++; if (acc_q.size() - ab !== 0 || busy !== 0) begin bad++; $display("FAIL rst_mid_idle got=acc%0d busy%0d exp=0/0", acc_q.size() - ab, busy); end
        pb = pix_q.size();
        pulse_frame();
        wait_valid(to);
        pixel_ready = 1'b1;
        wait_done(pb + NPIX, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%0d pixels exp=%0d", pix_q.size() - pb, NPIX); end
        for (int i = 0; i < NPIX; i++) begin
            total++;
            if (pix_q[pb + i].data !== exp_pix(i) || pix_q[pb + i].last !== (i == NPIX - 1)) begin
                bad++;
                $display("FAIL rst_mid_pix[%0d] got=%h l%b exp=%h l%b", i, pix_q[pb + i].data, pix_q[pb + i].last, exp_pix(i), i == NPIX - 1);
            end
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        frame_start = 1'b0;
        pixel_ready = 1'b0;
        mem_lat     = 1;
        stall_total = 0;
        test_reset();
        test_frame();
        test_backpressure();
        test_waitrequest();
        test_restart_drain();
        test_underflow();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
